// File: rtl/alu_pkg.sv
// Shared types for the nibble-serial subtractor: FSM states, flag bundle, nibble width.
package alu_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} alu_sub_state_t;

  typedef struct packed {
    logic z;
    logic n;
    logic h;
    logic c;
  } alu_flags_t;
endpackage

// File: rtl/alu_sub_serial_nibble_sub.sv
// 4-bit subtract cell with borrow-in/borrow-out; time-shared by alu_sub_serial.
module nibble_sub
  import alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                bin,
  output logic [NIBBLE_W-1:0] diff,
  output logic                bout
);
  logic [NIBBLE_W:0] full;

  // Extra top bit becomes 1 exactly when a < b + bin.
  assign full = {1'b0, a} - {1'b0, b} - {{NIBBLE_W{1'b0}}, bin};
  assign diff = full[NIBBLE_W-1:0];
  assign bout = full[NIBBLE_W];
endmodule

// File: rtl/alu_sub_serial.sv
// Nibble-serial 8-bit SUB/SBC/CP: low nibble then high nibble through one nibble_sub.
// ALU_SUB_CMP_EN adds the cmp port (CP mode: flags from subtraction, result = op_a).
module alu_sub_serial
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  input  logic       carry_in,
  input  logic       use_carry,
`ifdef ALU_SUB_CMP_EN
  input  logic       cmp,
`endif
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_h,
  output logic       flag_c
);
  alu_sub_state_t state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [NIBBLE_W-1:0] lo_q, lo_d;
  logic bin_q, bin_d, cmp_q, cmp_d, h_q, h_d, busy_q, busy_d, done_q, done_d;
  alu_flags_t flags_q, flags_d;

  logic cmp_s;
  logic [NIBBLE_W-1:0] cell_a, cell_b, cell_diff;
  logic cell_bin, cell_bout;

`ifdef ALU_SUB_CMP_EN
  assign cmp_s = cmp;
`else
  assign cmp_s = 1'b0;
`endif

  // LO feeds the low nibbles with the op's borrow-in; HI chains the stored half borrow.
  assign cell_a   = (state_q == LO) ? a_q[3:0] : a_q[7:4];
  assign cell_b   = (state_q == LO) ? b_q[3:0] : b_q[7:4];
  assign cell_bin = (state_q == LO) ? bin_q    : h_q;

  nibble_sub u_cell (
    .a    (cell_a),
    .b    (cell_b),
    .bin  (cell_bin),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    bin_d    = bin_q;
    cmp_d    = cmp_q;
    lo_d     = lo_q;
    h_d      = h_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE, DONE: begin
        busy_d = 1'b0;
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          bin_d   = use_carry & carry_in;
          cmp_d   = cmp_s;
          state_d = LO;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      LO: begin
        lo_d    = cell_diff;
        h_d     = cell_bout;
        state_d = HI;
      end
      HI: begin
        result_d  = cmp_q ? a_q : {cell_diff, lo_q};
        flags_d.z = ({cell_diff, lo_q} == 8'h00);
        flags_d.n = 1'b1;
        flags_d.h = h_q;
        flags_d.c = cell_bout;
        state_d   = DONE;
        busy_d    = 1'b0;
        done_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      bin_q    <= 1'b0;
      cmp_q    <= 1'b0;
      lo_q     <= '0;
      h_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      bin_q    <= bin_d;
      cmp_q    <= cmp_d;
      lo_q     <= lo_d;
      h_q      <= h_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign flag_z = flags_q.z;
  assign flag_n = flags_q.n;
  assign flag_h = flags_q.h;
  assign flag_c = flags_q.c;
endmodule

// File: tb/tb_alu_sub_serial.sv
// Bench for alu_sub_serial: integer-arithmetic reference with a cycle-level schedule, plus pinned literals.
module tb_alu_sub_serial;
  logic clk = 1'b0;
  logic reset_n, start, carry_in, use_carry, cmp;
  logic [7:0] op_a, op_b;
  logic busy, done, flag_z, flag_n, flag_h, flag_c;
  logic [7:0] result;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  alu_sub_serial dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op_a(op_a), .op_b(op_b),
    .carry_in(carry_in), .use_carry(use_carry),
`ifdef ALU_SUB_CMP_EN
    .cmp(cmp),
`endif
    .busy(busy), .done(done), .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_h(flag_h), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  logic cmp_eff;
`ifdef ALU_SUB_CMP_EN
  assign cmp_eff = cmp;
`else
  assign cmp_eff = 1'b0;
`endif

  // {z,n,h,c,result} from plain integer arithmetic
  function automatic logic [11:0] ref_op(input int a, input int b, input int bin, input logic cm);
    int d;
    logic z, h, c;
    logic [7:0] r;
    d = (a - b - bin + 512) % 256;
    z = (d == 0);
    h = ((a % 16) < (b % 16) + bin);
    c = (a < b + bin);
    r = cm ? a[7:0] : d[7:0];
    return {z, 1'b1, h, c, r};
  endfunction

  // Model: an accepted op completes two edges later; idle/done cycles accept a new start.
  int m_cnt;
  logic m_done;
  logic [11:0] m_out, pend;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_out  <= '0;
    end else if (m_cnt != 0) begin
      m_cnt  <= m_cnt - 1;
      m_done <= (m_cnt == 1);
      if (m_cnt == 1) m_out <= pend;
    end else begin
      m_done <= 1'b0;
      if (start === 1'b1) begin
        m_cnt <= 2;
        pend  <= ref_op(int'(op_a), int'(op_b), int'(use_carry & carry_in), cmp_eff);
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] outs();
    return {busy, done, flag_z, flag_n, flag_h, flag_c, result};
  endfunction

  always @(negedge clk)
    if (cmp_en) chk("cycle", {2'b00, outs()}, {2'b00, (m_cnt != 0), m_done, m_out});

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic uc, input logic cm, input logic st);
    op_a = a; op_b = b; carry_in = ci; use_carry = uc; cmp = cm; start = st;
  endtask

  // Issue one op at a negedge and return at the negedge where done is high (bounded).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic uc, input logic cm);
    int n;
    drive(a, b, ci, uc, cm, 1'b1);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {15'd0, done}, 16'd1);
  endtask

  initial begin
    reset_n = 1'b1;
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 reset_n = 1'b0;
    #3 chk("reset_state", {2'b00, outs()}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cmp_en = 1'b1;

    // SUB 0x10-0x01: done exactly two edges after the sampling edge, one cycle wide
    drive(8'h10, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); start = 1'b0;
    chk("t1_lat1", {15'd0, done}, 16'd0);
    chk("t1_busy", {15'd0, busy}, 16'd1);
    @(negedge clk);
    chk("t1_lat2", {15'd0, done}, 16'd0);
    @(negedge clk);
    chk("t1_lat3", {15'd0, done}, 16'd1);
    chk("t1_res", {4'd0, flag_z, flag_n, flag_h, flag_c, result}, {4'd0, 4'b0110, 8'h0F});
    @(negedge clk);
    chk("t1_pulse", {15'd0, done}, 16'd0);
    chk("t1_hold", {8'd0, result}, 16'h000F);

    run_op(8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("t2_ff", {4'd0, flag_z, flag_n, flag_h, flag_c, result}, {4'd0, 4'b0111, 8'hFF});
    run_op(8'h55, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("t2_zero", {4'd0, flag_z, flag_n, flag_h, flag_c, result}, {4'd0, 4'b1100, 8'h00});

    run_op(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("t3_sbc", {4'd0, flag_z, flag_n, flag_h, flag_c, result}, {4'd0, 4'b0111, 8'hFF});
    run_op(8'h3E, 8'h0F, 1'b1, 1'b0, 1'b0);
    chk("t3_nocarry", {4'd0, flag_z, flag_n, flag_h, flag_c, result}, {4'd0, 4'b0110, 8'h2F});

    // Restart pulses while busy are ignored; start in the done cycle is accepted
    @(negedge clk);
    drive(8'h20, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); drive(8'h99, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk); drive(8'h77, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t4_done1", {15'd0, done}, 16'd1);
    chk("t4_first", {4'd0, flag_z, flag_n, flag_h, flag_c, result}, {4'd0, 4'b0110, 8'h1F});
    drive(8'h80, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); start = 1'b0;
    chk("t4_gap1", {15'd0, done}, 16'd0);
    @(negedge clk);
    chk("t4_gap2", {15'd0, done}, 16'd0);
    @(negedge clk);
    chk("t4_done2", {15'd0, done}, 16'd1);
    chk("t4_second", {4'd0, flag_z, flag_n, flag_h, flag_c, result}, {4'd0, 4'b0110, 8'h7F});

    // Reset in the HI cycle clears everything at once and no done follows
    run_op(8'h12, 8'h01, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(8'hF0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk("t5_async", {2'b00, outs()}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_nodone", {15'd0, done}, 16'd0);
    end

`ifdef ALU_SUB_CMP_EN
    run_op(8'h3C, 8'h40, 1'b0, 1'b0, 1'b1);
    chk("t6_cp_lt", {4'd0, flag_z, flag_n, flag_h, flag_c, result}, {4'd0, 4'b0101, 8'h3C});
    run_op(8'h42, 8'h42, 1'b0, 1'b0, 1'b1);
    chk("t6_cp_eq", {4'd0, flag_z, flag_n, flag_h, flag_c, result}, {4'd0, 4'b1100, 8'h42});
`endif

    // Random traffic, including starts that land while busy
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      drive(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 2) == 0));
    end
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
